// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles every bus signal around the memory arbiter.
//   core side   : core_req, core_we, core_adr, core_wd -> arbiter; core_rd, core_stall <- arbiter
//   loader side : ld_req, ld_we, ld_adr, ld_wd, ld_lock -> arbiter; ld_rd, ld_ack <- arbiter
//   memory side : MemWrite, Adr, WriteData <- arbiter; ReadData -> arbiter
// The slave modport is the arbiter's view.
// The master modport is the view of the surrounding system: core, loader and memory.
interface mem_arbiter_if;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_adr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_adr;
  logic [31:0] ld_wd;
  logic        ld_lock;
  logic [31:0] ld_rd;
  logic        ld_ack;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport slave (
    input  core_req, core_we, core_adr, core_wd,
    output core_rd, core_stall,
    input  ld_req, ld_we, ld_adr, ld_wd, ld_lock,
    output ld_rd, ld_ack,
    output MemWrite, Adr, WriteData,
    input  ReadData
  );

  modport master (
    output core_req, core_we, core_adr, core_wd,
    input  core_rd, core_stall,
    output ld_req, ld_we, ld_adr, ld_wd, ld_lock,
    input  ld_rd, ld_ack,
    input  MemWrite, Adr, WriteData,
    output ReadData
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the unified instruction/data memory of the multi-cycle ARM core with a
// loader/debug master. The core is stalled while the loader owns the bus. A loader
// burst is bounded by BURST so the core is never starved.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - mem_arbiter_if.slave (core, loader and memory signals)
// Parameter:
//   BURST - maximum consecutive loader accesses before the core gets a slot (>= 1)
// Optional feature macro: MEM_ARB_LOCK_EN
//   When defined, ld_lock=1 keeps the loader on the bus past BURST.
//   When undefined, ld_lock is ignored.
module mem_arbiter #(
  parameter int BURST = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW:0] BURST_W = (CW + 1)'(BURST);

  localparam logic [0:0] OWN_CORE = 1'b0;
  localparam logic [0:0] OWN_LD   = 1'b1;

  logic [0:0]  owner;
  logic [CW-1:0] cnt;
  logic        ld_owns;
  logic        lock_hold;
  logic [CW:0] cnt_inc;
  logic        burst_done;

  assign ld_owns = (owner == OWN_LD);

`ifdef MEM_ARB_LOCK_EN
  assign lock_hold = bus.ld_lock;
`else
  logic unused_ld_lock;
  assign unused_ld_lock = bus.ld_lock;
  assign lock_hold = 1'b0;
`endif

  // The burst counter is evaluated one bit wider, so cnt+1 cannot wrap when cnt is saturated at BURST.
  assign cnt_inc    = {1'b0, cnt} + 1'b1;
  assign burst_done = (cnt_inc >= BURST_W);

  // Memory port mux and request gating.
  // This block has combinational paths from the requests and the owner register only.
  // A write reaches memory only when the owning side is actually requesting.
  always_comb begin
    bus.Adr        = ld_owns ? bus.ld_adr : bus.core_adr;
    bus.WriteData  = ld_owns ? bus.ld_wd  : bus.core_wd;
    bus.MemWrite   = ld_owns ? (bus.ld_we & bus.ld_req) : (bus.core_we & bus.core_req);
    bus.core_rd    = bus.ReadData;
    bus.ld_rd      = bus.ReadData;
    bus.core_stall = bus.core_req & ld_owns;
    bus.ld_ack     = bus.ld_req & ld_owns;
  end

  // Grant FSM.
  // The core always finishes its current access before yielding to a waiting loader.
  // The loader hands the bus back when it goes idle, or once its burst is spent while
  // the core is waiting. The counter saturates at BURST, so an idle core is granted
  // on its very first request.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= OWN_CORE;
      cnt   <= '0;
    end else if (owner == OWN_CORE) begin
      if (bus.ld_req) begin
        owner <= OWN_LD;
        cnt   <= '0;
      end
    end else begin
      if (!bus.ld_req) begin
        owner <= OWN_CORE;
        cnt   <= '0;
      end else if (burst_done && bus.core_req && !lock_hold) begin
        owner <= OWN_CORE;
        cnt   <= '0;
      end else if (burst_done) begin
        cnt   <= BURST_W[CW-1:0];
      end else begin
        cnt   <= cnt_inc[CW-1:0];
      end
    end
  end

endmodule
